// File: rtl/gnr_sweep_ctrl_if.sv
// Result channel of the gene-regulatory-network sweep controller.
// One transfer per initial state, valid/ready handshake.
interface gnr_sweep_ctrl_if #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [NUM_NODES-1:0] res_init;
  logic [NUM_NODES-1:0] res_state;
  logic [CNT_W-1:0]     res_steps;
  logic                 res_timeout;

  // Producer side: the sweep controller
  modport master (
    output res_valid, res_init, res_state, res_steps, res_timeout,
    input  res_ready
  );

  // Consumer side: whoever collects the attractor results
  modport slave (
    input  res_valid, res_init, res_state, res_steps, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/gnr_sweep_ctrl.sv
// Sweep controller for boolean gene-regulatory-network nodes.
// For each initial state in [first..last] (wrapping modulo 2^NUM_NODES) it
// loads the nodes, then advances a slow (s0) and fast (s1) trajectory with
// Floyd cycle detection until the two meet or MAX_STEPS pulses elapse, and
// reports the outcome on the result interface.
module gnr_sweep_ctrl #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] cfg_init_first,
  input  logic [NUM_NODES-1:0] cfg_init_last,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  gnr_sweep_ctrl_if.master     res_if
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] MIN_CMP = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_REPORT
  } state_t;

  state_t               r_state;
  logic [NUM_NODES-1:0] r_cur_init;
  logic [NUM_NODES-1:0] r_init_last;
  logic [CNT_W-1:0]     r_step_cnt;
  logic                 r_reset_nos;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_res_valid;
  logic [NUM_NODES-1:0] r_res_init;
  logic [NUM_NODES-1:0] r_res_state;
  logic [CNT_W-1:0]     r_res_steps;
  logic                 r_res_timeout;

  logic w_run;
  logic w_match;
  logic w_tmo;
  logic w_step;

  // After k pulses s0 = x[ceil(k/2)], s1 = x[k]; only even k >= 2 is a
  // genuine slow/fast comparison (at k = 1 both sit on x[1]).
  assign w_run   = (r_state == ST_RUN);
  assign w_match = w_run && !r_step_cnt[0] && (r_step_cnt >= MIN_CMP) &&
                   (s0_vec == s1_vec);
  assign w_tmo   = w_run && (r_step_cnt == MAX_CNT) && !w_match;
  // Combinational so that no pulse leaks out in the detection cycle.
  assign w_step  = w_run && !w_match && !w_tmo;

  assign start_s0   = w_step;
  assign start_s1   = w_step;
  assign reset_nos  = r_reset_nos;
  assign init_state = r_cur_init;
  assign busy       = r_busy;
  assign done       = r_done;

  assign res_if.res_valid   = r_res_valid;
  assign res_if.res_init    = r_res_init;
  assign res_if.res_state   = r_res_state;
  assign res_if.res_steps   = r_res_steps;
  assign res_if.res_timeout = r_res_timeout;

  // Sweep FSM with registered outputs; reset aborts any run in progress.
  // NOTE: state is written with non-blocking assignments so every branch sees
  // the pre-edge values, exactly as the flops do in hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_init    <= '0;
      r_init_last   <= '0;
      r_step_cnt    <= '0;
      r_reset_nos   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_init    <= '0;
      r_res_state   <= '0;
      r_res_steps   <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_reset_nos <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_init  <= cfg_init_first;
            r_init_last <= cfg_init_last;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_reset_nos <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_step_cnt <= '0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (w_match || w_tmo) begin
            r_res_init    <= r_cur_init;
            r_res_state   <= s1_vec;
            r_res_steps   <= r_step_cnt;
            r_res_timeout <= w_tmo;
            r_res_valid   <= 1'b1;
            r_state       <= ST_REPORT;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          if (r_res_valid && res_if.res_ready) begin
            r_res_valid <= 1'b0;
            if (r_cur_init == r_init_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              // Natural wrap of the NUM_NODES-bit index lets first > last
              // sweep through all-ones back to zero.
              r_cur_init  <= r_cur_init + 1'b1;
              r_reset_nos <= 1'b1;
              r_state     <= ST_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_sweep_ctrl.sv
// Directed bench for gnr_sweep_ctrl with a behavioural node array whose
// next-state function is selected per scenario.
module tb_gnr_sweep_ctrl;

  localparam int NN = 8;
  localparam int CW = 16;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NN-1:0] cfg_init_first = '0;
  logic [NN-1:0] cfg_init_last = '0;
  logic [NN-1:0] s0_vec;
  logic [NN-1:0] s1_vec;
  logic          reset_nos;
  logic [NN-1:0] init_state;
  logic          start_s0;
  logic          start_s1;
  logic          busy;
  logic          done;

  gnr_sweep_ctrl_if #(.NUM_NODES(NN), .CNT_W(CW)) res_bus ();

  gnr_sweep_ctrl #(.NUM_NODES(NN), .CNT_W(CW), .MAX_STEPS(MS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_init_first(cfg_init_first),
    .cfg_init_last (cfg_init_last),
    .s0_vec        (s0_vec),
    .s1_vec        (s1_vec),
    .reset_nos     (reset_nos),
    .init_state    (init_state),
    .start_s0      (start_s0),
    .start_s1      (start_s1),
    .busy          (busy),
    .done          (done),
    .res_if        (res_bus.master)
  );

  always #5 clk = ~clk;

  // Node model: 0 = fixed point, 1 = increment mod 3, 2 = increment mod 256
  int            mode = 0;
  logic [NN-1:0] ns0 = '0;
  logic [NN-1:0] ns1 = '0;
  logic          npass = 1'b1;

  function automatic logic [NN-1:0] f_next(input logic [NN-1:0] x, input int m);
    case (m)
      0:       return x;
      1:       return (x >= 8'd2) ? 8'd0 : x + 8'd1;
      default: return x + 8'd1;
    endcase
  endfunction

  assign s0_vec = ns0;
  assign s1_vec = ns1;

  // Nodes: load on reset_nos; s1 moves every pulse, s0 on odd pulses
  always @(posedge clk) begin
    if (reset_nos) begin
      ns0   <= init_state;
      ns1   <= init_state;
      npass <= 1'b1;
    end else begin
      if (start_s1) ns1 <= f_next(ns1, mode);
      if (start_s0) begin
        if (npass) ns0 <= f_next(ns0, mode);
        npass <= ~npass;
      end
    end
  end

  // Event monitor: cycle counter, pulse/load tallies, strobe pairing
  int   cyc = 0;
  int   n_pulse = 0;
  int   n_load = 0;
  int   load_cyc = 0;
  int   n_strobe_diff = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_s0) n_pulse <= n_pulse + 1;
    if (reset_nos) begin
      n_load   <= n_load + 1;
      load_cyc <= cyc;
    end
    if (start_s0 !== start_s1) n_strobe_diff <= n_strobe_diff + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int p_base = 0;
  int l_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [NN-1:0] first, input logic [NN-1:0] last);
    cfg_init_first = first;
    cfg_init_last  = last;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p_base = n_pulse;
    l_base = n_load;
    check("load_strobe", reset_nos, 1);
    check("load_init", init_state, first);
    check("load_busy", busy, 1);
    check("load_done_clr", done, 0);
  endtask

  task automatic take_result(input string tag, input logic [NN-1:0] e_init,
                             input logic [NN-1:0] e_state, input int e_steps,
                             input logic e_tmo, input int hold);
    int k = 0;
    int p0, l0;
    while (!res_bus.res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, res_bus.res_valid, 1);
    check({tag, "_init"}, res_bus.res_init, e_init);
    check({tag, "_state"}, res_bus.res_state, e_state);
    check({tag, "_steps"}, res_bus.res_steps, e_steps);
    check({tag, "_tmo"}, res_bus.res_timeout, e_tmo);
    check({tag, "_pulses"}, n_pulse - p_base, e_steps);
    check({tag, "_loads"}, n_load - l_base, 1);
    check({tag, "_latency"}, cyc - load_cyc, e_steps + 2);
    if (hold > 0) begin
      p0 = n_pulse;
      l0 = n_load;
      res_bus.res_ready = 1'b0;
      tick(hold);
      check({tag, "_hold_valid"}, res_bus.res_valid, 1);
      check({tag, "_hold_init"}, res_bus.res_init, e_init);
      check({tag, "_hold_state"}, res_bus.res_state, e_state);
      check({tag, "_hold_steps"}, res_bus.res_steps, e_steps);
      check({tag, "_hold_pulses"}, n_pulse - p0, 0);
      check({tag, "_hold_loads"}, n_load - l0, 0);
    end
    res_bus.res_ready = 1'b1;
    @(negedge clk);
    res_bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_bus.res_valid, 0);
    p_base = n_pulse;
    l_base = n_load;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reset_nos"}, reset_nos, 0);
    check({tag, "_init_state"}, init_state, 0);
    check({tag, "_start_s0"}, start_s0, 0);
    check({tag, "_start_s1"}, start_s1, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res_valid"}, res_bus.res_valid, 0);
    check({tag, "_res_init"}, res_bus.res_init, 0);
    check({tag, "_res_state"}, res_bus.res_state, 0);
    check({tag, "_res_steps"}, res_bus.res_steps, 0);
    check({tag, "_res_tmo"}, res_bus.res_timeout, 0);
  endtask

  initial begin
    int k;
    res_bus.res_ready = 1'b0;

    // Reset state
    tick(3);
    check_all_zero("rst");
    rst = 1'b0;
    tick(1);

    // Fixed point f(x) = x, single state 05
    mode = 0;
    do_start(8'h05, 8'h05);
    take_result("fix", 8'h05, 8'h05, 2, 1'b0, 0);
    check("fix_done", done, 1);
    check("fix_busy", busy, 0);

    // Period-3 cycle from 0: first genuine meeting at step 6
    mode = 1;
    do_start(8'h00, 8'h00);
    take_result("p3", 8'h00, 8'h00, 6, 1'b0, 0);
    check("p3_done", done, 1);

    // Timeout with mod-256 counter; a start while busy must be ignored
    mode = 2;
    do_start(8'h00, 8'h00);
    tick(3);
    cfg_init_first = 8'h77;
    cfg_init_last  = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    take_result("tmo", 8'h00, 8'h10, MS, 1'b1, 0);
    check("tmo_done", done, 1);
    check("tmo_busy", busy, 0);

    // Sweep 3..5 with 10 cycles of backpressure on the first result
    mode = 0;
    do_start(8'h03, 8'h05);
    take_result("bp3", 8'h03, 8'h03, 2, 1'b0, 10);
    check("bp_not_done", done, 0);
    take_result("bp4", 8'h04, 8'h04, 2, 1'b0, 0);
    take_result("bp5", 8'h05, 8'h05, 2, 1'b0, 0);
    check("bp_done", done, 1);

    // Wrap FF -> 00 -> 01
    do_start(8'hFF, 8'h01);
    take_result("wrFF", 8'hFF, 8'hFF, 2, 1'b0, 0);
    take_result("wr00", 8'h00, 8'h00, 2, 1'b0, 0);
    take_result("wr01", 8'h01, 8'h01, 2, 1'b0, 0);
    check("wr_done", done, 1);

    // Reset in RUN at step_cnt = 7
    mode = 2;
    do_start(8'h10, 8'h10);
    k = 0;
    while ((n_pulse - p_base) < 7 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_pulses", n_pulse - p_base, 7);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid");
    rst = 1'b0;
    p_base = n_pulse;
    tick(4);
    check("mid_idle_pulses", n_pulse - p_base, 0);
    check("mid_idle_valid", res_bus.res_valid, 0);

    // Normal run after the abort
    mode = 0;
    do_start(8'h21, 8'h21);
    take_result("post", 8'h21, 8'h21, 2, 1'b0, 0);
    check("post_done", done, 1);

    check("strobe_pairing", n_strobe_diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
